// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - N-to-1 round-robin valid/ready stream arbiter with two-entry output buffer
//
// Purpose:
//   Merges N requester streams onto one downstream channel. A rotating
//   priority pointer picks the next requester, so producers are served fairly.
//   A two-entry ping-pong buffer registers every downstream output. It
//   sustains one beat per cycle without a combinational path from dn_rdy
//   back to up_rdy.
//
// Configuration:
//   STRM_ARB_PKT_LOCK_EN - when defined, a grant is held for the whole packet,
//   up to the beat with up_last set. When undefined, arbitration rotates after
//   every beat. up_last is then only carried through to dn_last.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   up_vld   - [N]     per-requester beat valid
//   up_dat   - [N*W]   per-requester data, requester k at [k*W +: W]
//   up_last  - [N]     per-requester last-beat flag
//   up_rdy   - [N]     per-requester ready (one-hot or zero)
//   dn_vld   - downstream beat valid
//   dn_dat   - [W]     downstream data
//   dn_last  - downstream last flag
//   dn_id    - [IDW]   source requester index of the current beat
//   dn_rdy   - downstream ready
module stream_rr_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     up_vld,
  input  logic [N*W-1:0]   up_dat,
  input  logic [N-1:0]     up_last,
  output logic [N-1:0]     up_rdy,
  output logic             dn_vld,
  output logic [W-1:0]     dn_dat,
  output logic             dn_last,
  output logic [IDW-1:0]   dn_id,
  input  logic             dn_rdy
);

  // Rotating priority pointer: the requester searched first.
  logic [IDW-1:0] ptr;

  // Lock tracking. The lock is a constant zero in the beat-interleaving build.
  logic           locked;
  logic [IDW-1:0] lock_id;

  // Arbitration result from the round-robin search.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;

  // Selected source and its beat.
  logic [IDW-1:0] sel;
  logic [W-1:0]   sel_dat;
  logic           sel_last;
  logic           accept;

  // Ping-pong buffer storage.
  logic [1:0]     full;
  logic           wr_bank;
  logic           rd_bank;
  logic [W-1:0]   buf_dat  [2];
  logic           buf_last [2];
  logic [IDW-1:0] buf_id   [2];
  logic           space;

  logic [W-1:0]   up_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign up_arr[k] = up_dat[k*W +: W];
  end

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] k);
    return (k == IDW'(N-1)) ? '0 : k + 1'b1;
  endfunction

  // Space depends only on buffer state. This keeps dn_rdy out of the
  // up_rdy cone.
  assign space = ~(full[0] & full[1]);

  // First valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDW'((int'(ptr) + i) % N);
      if (!gnt_found && up_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign sel = locked ? lock_id : gnt_idx;

  always_comb begin
    up_rdy = '0;
    if (!rst) begin
      if (locked) begin
        up_rdy[lock_id] = space;
      end else if (gnt_found) begin
        up_rdy[gnt_idx] = space;
      end
    end
  end

  assign accept   = |(up_vld & up_rdy);
  assign sel_dat  = up_arr[sel];
  assign sel_last = up_last[sel];

`ifdef STRM_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_id <= '0;
      ptr     <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        if (sel_last) begin
          ptr <= next_idx(gnt_idx);
        end else begin
          state   <= LOCKED;
          lock_id <= gnt_idx;
        end
      end else if (sel_last) begin
        state <= IDLE;
        ptr   <= next_idx(lock_id);
      end
    end
  end
`else
  assign locked  = 1'b0;
  assign lock_id = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= next_idx(gnt_idx);
    end
  end
`endif

  // When the buffer is empty or full, wr_bank equals rd_bank. A write
  // needs space, and a read needs a full entry. So a write and a read in
  // the same cycle always go to different entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      buf_dat[0]  <= '0;
      buf_dat[1]  <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      buf_id[0]   <= '0;
      buf_id[1]   <= '0;
    end else begin
      if (accept) begin
        buf_dat[wr_bank]  <= sel_dat;
        buf_last[wr_bank] <= sel_last;
        buf_id[wr_bank]   <= sel;
        full[wr_bank]     <= 1'b1;
        wr_bank           <= ~wr_bank;
      end
      if (dn_vld && dn_rdy) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  assign dn_vld  = full[rd_bank];
  assign dn_dat  = buf_dat[rd_bank];
  assign dn_last = buf_last[rd_bank];
  assign dn_id   = buf_id[rd_bank];

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- N-input to 1-output valid/ready stream arbiter with round-robin fairness and packet lock.
- Merges several requester streams (each a sequence of beats terminated by a last flag) onto one shared downstream channel.
- Internal two-entry ping-pong output buffer sustains one beat per cycle and registers every downstream output.
- Sits in front of shared NPU datapath resources (memory write port, PE array input) that several producers feed.

Parameters:
- N, 4, number of requester ports (2..16).
- W, 32, data width per beat in bits (multiple of 8).
- IDW, 2, width of dn_id; must equal max(1, clog2(N)).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- up_vld  input  N  per-requester beat valid.
- up_dat  input  N*W  per-requester data; requester k occupies bits [k*W +: W].
- up_last  input  N  per-requester last-beat-of-packet flag.
- up_rdy  output  N  per-requester ready; at most one bit high in any cycle.
- dn_vld  output  1  downstream beat valid.
- dn_dat  output  W  downstream data.
- dn_last  output  1  downstream last flag.
- dn_id  output  IDW  index of the requester that sourced the beat.
- dn_rdy  input  1  downstream ready.

Behaviour:
- Reset, rst=1 sampled at a clock edge:
  - dn_vld=0, dn_dat=0, dn_last=0, dn_id=0.
  - Both buffer entries empty; state=IDLE; rr pointer ptr=0.
  - up_rdy=0 while rst is high.
- Reset mid-packet abandons the lock and discards buffered beats; no partial-packet recovery.
- Buffer: two entries, written alternately (wr_bank) and read alternately (rd_bank).
  - space = not both entries full.
  - dn_* always reflect entry rd_bank.
  - Beat transfers when dn_vld & dn_rdy; entry frees, rd_bank toggles.
  - Simultaneous write and read in the same cycle are allowed; occupancy unchanged.
- Latency: a beat accepted upstream in cycle t appears on dn_* at cycle t+1 when the buffer was empty.
- Throughput: 1 beat/cycle with dn_rdy held high.
- Upstream handshake: beat from requester k accepted when up_vld[k] & up_rdy[k]. up_rdy is combinational from up_vld, state, ptr and space; no combinational path from dn_rdy.
- State IDLE:
  - g = first k with up_vld[k]=1, searching ptr, ptr+1, ..., ptr+N-1 (mod N).
  - up_rdy[g]=space; all other up_rdy bits 0.
  - If accepted and up_last[g]=1: stay IDLE, ptr <= (g+1) mod N.
  - If accepted and up_last[g]=0: go LOCKED, lock_id <= g.
  - No up_vld set, or space=0: no change.
- State LOCKED:
  - up_rdy[lock_id]=space; all other bits 0.
  - Other requesters wait regardless of their valids.
  - On an accepted beat with up_last=1: go IDLE, ptr <= (lock_id+1) mod N.
- ptr wraps from N-1 to 0.
- A requester that drops up_vld mid-packet keeps the lock. The arbiter stalls that port indefinitely; it is never a timeout.
- dn_id carries the source index and is stored per buffer entry with the data.
- up_vld on a requester without grant: no effect; that requester must hold its beat stable until granted.

Optional Feature:
- Macro STRM_ARB_PKT_LOCK_EN.
- Defined: packet lock as described above.
- Undefined:
  - LOCKED state is removed and up_last is ignored for arbitration.
  - After every accepted beat, ptr <= (g+1) mod N.
  - Beats from different requesters may interleave; dn_last and dn_id still pass through per beat.

Test Plan:
- Reset then idle: rst high 2 cycles, N=4, all up_vld=0 -> dn_vld=0, up_rdy=0000 during reset; up_rdy stays 0000 after release.
- Round-robin single beats: up_vld=1111, up_last=1111, dn_rdy=1 continuous -> dn_id sequence 0,1,2,3,0 on consecutive cycles, first dn_vld one cycle after first accept.
- Packet lock (macro defined): req0 sends 3 beats (last on the 3rd), req1 valid throughout -> dn_id=0,0,0,1 and up_rdy[1]=0 until req0 last is accepted.
- Backpressure: dn_rdy=0 with up_vld=0001 -> exactly 2 beats accepted, then up_rdy=0. Release dn_rdy -> the beats emerge in order with data intact, then streaming resumes.
- Pointer wrap and skip: ptr=3, up_vld=0101 -> grant 0, then 2. With up_vld=1000 alone -> grant 3, ptr becomes 0.
- Reset mid-packet: rst during LOCKED with 1 buffered beat -> next cycle dn_vld=0, state IDLE, ptr=0. A fresh request from req2 is granted without waiting for the old last beat.
